// File: rtl/threshold_commander.sv
// threshold_commander: host-side initiator for the threshold-tuning UART command protocol
module threshold_commander #(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_mode,
  input  logic        req_dir,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_idle,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_value,
  output logic [2:0]  rsp_mode,
  output logic        err_echo,
  output logic        err_timeout,
  output logic        err_cmd,
  output logic        busy
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {
    IDLE, SEND_MODE, WAIT_MODE_ECHO, SEND_DIR, WAIT_DIR_ECHO, WAIT_B0, WAIT_B1
  } state_t;
  state_t        state_q, state_d;
  logic [2:0]    mode_q, mode_d;
  logic          dir_q, dir_d;
  logic [7:0]    low_q, low_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [15:0]   rsp_value_q, rsp_value_d;
  logic [2:0]    rsp_mode_q, rsp_mode_d;
  logic          err_echo_q, err_echo_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_cmd_q, err_cmd_d;
  logic          waiting;
  // State and output registers; reset discards any partial response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mode_q        <= '0;
      dir_q         <= 1'b0;
      low_q         <= '0;
      tx_data_q     <= '0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_value_q   <= '0;
      rsp_mode_q    <= '0;
      err_echo_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_cmd_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      dir_q         <= dir_d;
      low_q         <= low_d;
      tx_data_q     <= tx_data_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_value_q   <= rsp_value_d;
      rsp_mode_q    <= rsp_mode_d;
      err_echo_q    <= err_echo_d;
      err_timeout_q <= err_timeout_d;
      err_cmd_q     <= err_cmd_d;
    end
  end
  // Next-state: send chars, check echoes, collect response bytes, bound every wait
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    dir_d         = dir_q;
    low_d         = low_q;
    tx_data_d     = tx_data_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = 1'b0;
    rsp_value_d   = rsp_value_q;
    rsp_mode_d    = rsp_mode_q;
    err_echo_d    = 1'b0;
    err_timeout_d = 1'b0;
    err_cmd_d     = 1'b0;
    waiting       = state_q inside {WAIT_MODE_ECHO, WAIT_DIR_ECHO, WAIT_B0, WAIT_B1};
    if (waiting) cnt_d = cnt_q + CW'(1);
    if (waiting && !rx_ready && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
      err_timeout_d = 1'b1;
      state_d       = IDLE;
    end
    case (state_q)
      IDLE: if (req_valid) begin
        if (req_mode == 3'd7) err_cmd_d = 1'b1;
        else begin
          mode_d    = req_mode;
          dir_d     = req_dir;
          tx_data_d = 8'h41 + {5'd0, req_mode};
          state_d   = SEND_MODE;
        end
      end
      SEND_MODE: if (tx_idle) begin
        state_d = WAIT_MODE_ECHO;
        cnt_d   = '0;
      end
      WAIT_MODE_ECHO: if (rx_ready) begin
        if (rx_data == tx_data_q) begin
          tx_data_d = dir_q ? 8'h77 : 8'h73;
          state_d   = SEND_DIR;
        end else begin
          err_echo_d = 1'b1;
          state_d    = IDLE;
        end
      end
      SEND_DIR: if (tx_idle) begin
        state_d = WAIT_DIR_ECHO;
        cnt_d   = '0;
      end
      WAIT_DIR_ECHO: if (rx_ready) begin
        if (rx_data == tx_data_q) begin
          state_d = WAIT_B0;
          cnt_d   = '0;
        end else begin
          err_echo_d = 1'b1;
          state_d    = IDLE;
        end
      end
      WAIT_B0: if (rx_ready) begin
        low_d = rx_data;
        if (mode_q == 3'd0) begin
          state_d = WAIT_B1;
          cnt_d   = '0;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_value_d = {{8{rx_data[7]}}, rx_data};
          rsp_mode_d  = mode_q;
          state_d     = IDLE;
        end
      end
      WAIT_B1: if (rx_ready) begin
        rsp_valid_d = 1'b1;
        rsp_value_d = {rx_data, low_q};
        rsp_mode_d  = mode_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign req_ready   = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign tx_start    = tx_idle && (state_q == SEND_MODE || state_q == SEND_DIR);
  assign tx_data     = tx_data_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_value   = rsp_value_q;
  assign rsp_mode    = rsp_mode_q;
  assign err_echo    = err_echo_q;
  assign err_timeout = err_timeout_q;
  assign err_cmd     = err_cmd_q;
endmodule

// File: tb/tb_threshold_commander.sv
// tb_threshold_commander: table-driven and scoreboarded check of the threshold command initiator
module tb_threshold_commander;
  logic        clk, rst, req_valid, req_ready, req_dir, tx_start, tx_idle, rx_ready;
  logic        rsp_valid, err_echo, err_timeout, err_cmd, busy;
  logic [2:0]  req_mode, rsp_mode;
  logic [7:0]  tx_data, rx_data;
  logic [15:0] rsp_value;
  int checks = 0;
  int errors = 0;
  logic [15:0] last_val = 16'h0;
  typedef struct {
    logic [2:0]  mode;
    logic        dir;
    logic [7:0]  c0, c1, e0, e1, b0, b1;
    int          kind;
    logic [15:0] val;
  } vec_t;
  typedef struct {
    int          kind;
    logic [15:0] val;
    logic [2:0]  mode;
  } evt_t;
  vec_t       tbl[9];
  logic [7:0] exp_tx[$];
  evt_t       exp_evt[$];
  threshold_commander #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_dir(req_dir), .tx_data(tx_data), .tx_start(tx_start),
    .tx_idle(tx_idle), .rx_data(rx_data), .rx_ready(rx_ready), .rsp_valid(rsp_valid),
    .rsp_value(rsp_value), .rsp_mode(rsp_mode), .err_echo(err_echo),
    .err_timeout(err_timeout), .err_cmd(err_cmd), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_evt(input int k, input logic [15:0] v, input logic [2:0] m);
    evt_t e;
    e.kind = k;
    e.val  = v;
    e.mode = m;
    exp_evt.push_back(e);
  endtask
  task automatic rx(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask
  task automatic wait_ready();
    for (int i = 0; i < 100 && !req_ready; i++) tick();
    chk("req_ready wait", req_ready, 1);
  endtask
  task automatic wait_tx();
    for (int i = 0; i < 200 && !tx_start; i++) tick();
    chk("tx_start wait", tx_start, 1);
  endtask
  task automatic start(input logic [2:0] m, input logic d);
    wait_ready();
    req_valid = 1'b1;
    req_mode  = m;
    req_dir   = d;
    tick();
    req_valid = 1'b0;
  endtask
  task automatic send_ok(input logic [7:0] c);
    exp_tx.push_back(c);
    wait_tx();
    tick();
    rx(c);
  endtask
  task automatic run(input vec_t v);
    expect_evt(v.kind, v.val, v.mode);
    start(v.mode, v.dir);
    if (v.kind != 3) begin
      exp_tx.push_back(v.c0);
      wait_tx();
      tick();
      rx(v.e0);
      if (v.e0 == v.c0) begin
        exp_tx.push_back(v.c1);
        wait_tx();
        tick();
        rx(v.e1);
        if (v.e1 == v.c1) begin
          rx(v.b0);
          if (v.mode == 3'd0) rx(v.b1);
        end
      end
    end
    tick();
    tick();
    if (v.kind == 0) last_val = v.val;
    else chk("rsp_value held", rsp_value, last_val);
  endtask
  task automatic monitor();
    int   n, k;
    evt_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (tx_start) begin
          if (exp_tx.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_start: got byte %0h, expected no transmission", tx_data);
          end else chk("tx_data", tx_data, exp_tx.pop_front());
        end
        n = int'(rsp_valid) + int'(err_echo) + int'(err_timeout) + int'(err_cmd);
        if (n != 0) begin
          chk("pulse exclusive", n, 1);
          chk("req_ready at pulse", req_ready, 1);
          k = rsp_valid ? 0 : err_echo ? 1 : err_timeout ? 2 : 3;
          if (exp_evt.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL event: got kind %0d, expected none", k);
          end else begin
            e = exp_evt.pop_front();
            chk("event kind", k, e.kind);
            if (k == 0) begin
              chk("rsp_value", rsp_value, e.val);
              chk("rsp_mode", rsp_mode, e.mode);
            end
          end
        end
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{3'd0, 1'b1, 8'h41, 8'h77, 8'h41, 8'h77, 8'h28, 8'h0A, 0, 16'h0A28};
    tbl[1] = '{3'd2, 1'b0, 8'h43, 8'h73, 8'h43, 8'h73, 8'hF4, 8'h00, 0, 16'hFFF4};
    tbl[2] = '{3'd3, 1'b0, 8'h44, 8'h73, 8'h45, 8'h00, 8'h00, 8'h00, 1, 16'h0000};
    tbl[3] = '{3'd6, 1'b1, 8'h47, 8'h77, 8'h47, 8'h77, 8'h05, 8'h00, 0, 16'h0005};
    tbl[4] = '{3'd1, 1'b0, 8'h42, 8'h73, 8'h42, 8'h73, 8'h80, 8'h00, 0, 16'hFF80};
    tbl[5] = '{3'd7, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3, 16'h0000};
    tbl[6] = '{3'd0, 1'b0, 8'h41, 8'h73, 8'h41, 8'h73, 8'hFF, 8'hFF, 0, 16'hFFFF};
    tbl[7] = '{3'd5, 1'b1, 8'h46, 8'h77, 8'h46, 8'h73, 8'h00, 8'h00, 1, 16'h0000};
    tbl[8] = '{3'd4, 1'b1, 8'h45, 8'h77, 8'h45, 8'h77, 8'h7F, 8'h00, 0, 16'h007F};
    rst = 1'b1;
    req_valid = 1'b0;
    req_mode = 3'd0;
    req_dir = 1'b0;
    tx_idle = 1'b1;
    rx_data = 8'h00;
    rx_ready = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset req_ready", req_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset tx_start", tx_start, 0);
    chk("reset tx_data", tx_data, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_value", rsp_value, 0);
    chk("reset rsp_mode", rsp_mode, 0);
    chk("reset errors", {err_echo, err_timeout, err_cmd}, 0);
    for (int i = 0; i < 9; i++) run(tbl[i]);
    // Timeout: no response byte after the dir echo
    expect_evt(2, 16'h0, 3'd0);
    start(3'd3, 1'b1);
    send_ok(8'h44);
    send_ok(8'h77);
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 15) chk("timeout not early", err_timeout, 0);
      if (k == 16) chk("timeout at 16", err_timeout, 1);
    end
    tick();
    chk("rsp_value after timeout", rsp_value, last_val);
    // Byte arriving in the expiry cycle wins over the timeout
    expect_evt(0, 16'h0012, 3'd2);
    start(3'd2, 1'b0);
    send_ok(8'h43);
    send_ok(8'h73);
    repeat (15) tick();
    rx(8'h12);
    chk("expiry rsp_valid", rsp_valid, 1);
    chk("expiry err_timeout", err_timeout, 0);
    last_val = 16'h0012;
    tick();
    tick();
    // Transmitter busy for 50 cycles: stall without timing out
    tx_idle = 1'b0;
    expect_evt(0, 16'hFFF0, 3'd1);
    start(3'd1, 1'b1);
    exp_tx.push_back(8'h42);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("stalled tx_start", tx_start, 0);
    end
    chk("stalled busy", busy, 1);
    chk("stalled err_timeout", err_timeout, 0);
    tx_idle = 1'b1;
    #1;
    chk("tx_start on idle", tx_start, 1);
    tick();
    rx(8'h42);
    send_ok(8'h77);
    rx(8'hF0);
    tick();
    tick();
    last_val = 16'hFFF0;
    // Reset while waiting for the second solar byte
    start(3'd0, 1'b1);
    send_ok(8'h41);
    send_ok(8'h77);
    rx(8'h55);
    chk("in WAIT_B1 busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid reset busy", busy, 0);
    chk("mid reset req_ready", req_ready, 1);
    chk("mid reset rsp_value", rsp_value, 0);
    chk("mid reset rsp_mode", rsp_mode, 0);
    chk("mid reset tx_data", tx_data, 0);
    chk("mid reset pulses", {rsp_valid, err_echo, err_timeout, err_cmd, tx_start}, 0);
    tick();
    tick();
    rst = 1'b0;
    last_val = 16'h0;
    expect_evt(0, 16'h1234, 3'd0);
    start(3'd0, 1'b1);
    send_ok(8'h41);
    send_ok(8'h77);
    rx(8'h34);
    rx(8'h12);
    tick();
    tick();
    chk("post reset rsp_value", rsp_value, 16'h1234);
    chk("tx queue drained", exp_tx.size(), 0);
    chk("event queue drained", exp_evt.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
